// File: rtl/btle_crc_tx_seq.sv
// -----------------------------------------------------------------------------
// btle_crc_tx_seq
//
// Transmit-side sequencer in front of crc24. For one packet it presets the CRC
// register, then feeds preamble, access address and PDU into crc24 one on-air
// bit at a time (one bit slot = CLK_PER_BIT clocks). After the last PDU bit it
// waits for crc24 to report the end of its 24 CRC bits, then pulses done.
//
// Optional feature: define BTLE_CRC_SEQ_TIMEOUT_EN to add a watchdog in the
// CRC wait state and the timeout_err output.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle send request, ignored while busy
//   access_address           AA, sampled on accepted start
//   crc_init                 CRC preset, sampled on accepted start
//   pdu_len                  PDU length in bytes, sampled on accepted start
//   pdu_addr                 byte address into the PDU buffer
//   pdu_data                 buffer read data, one clock after pdu_addr
//   crc_out_valid_last       crc24 has emitted its final CRC bit
//   crc_state_init_bit       CRC preset value to crc24 (during load only)
//   crc_state_init_bit_load  CRC preset strobe to crc24
//   info_bit                 current bit, held for the whole bit slot
//   info_bit_valid           one-clock strobe at the start of each bit slot
//   info_bit_valid_last      coincident with the strobe of the final bit
//   busy                     high from accepted start until done
//   done                     one-clock completion pulse
//   dbg_state                current FSM state, for debug/checkers
//   timeout_err              (feature only) done was caused by the watchdog
//
// Handshake: start is a single-cycle request that is only taken in IDLE; there
// is no back-pressure toward crc24 -- every info_bit_valid strobe is consumed
// in the clock it is presented.
// -----------------------------------------------------------------------------
module btle_crc_tx_seq #(
  parameter int CLK_PER_BIT         = 16,
  parameter int CRC_STATE_BIT_WIDTH = 24,
  parameter int LEN_WIDTH           = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [31:0]                    access_address,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_init,
  input  logic [LEN_WIDTH-1:0]           pdu_len,
  output logic [LEN_WIDTH-1:0]           pdu_addr,
  input  logic [7:0]                     pdu_data,
  input  logic                           crc_out_valid_last,
  output logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  output logic                           crc_state_init_bit_load,
  output logic                           info_bit,
  output logic                           info_bit_valid,
  output logic                           info_bit_valid_last,
  output logic                           busy,
  output logic [2:0]                     dbg_state,
  output logic                           done
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD        = 3'd1,
    S_PREAMBLE    = 3'd2,
    S_ACCESS_ADDR = 3'd3,
    S_PDU         = 3'd4,
    S_WAIT_CRC    = 3'd5,
    S_DONE        = 3'd6
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(CLK_PER_BIT - 1);

  state_e                         state_q, state_d;
  logic [31:0]                    aa_q, aa_d;
  logic [CRC_STATE_BIT_WIDTH-1:0] crc_q, crc_d;
  logic [LEN_WIDTH-1:0]           len_q, len_d;
  logic [LEN_WIDTH-1:0]           addr_q, addr_d;
  logic [LEN_WIDTH-1:0]           byte_cnt_q, byte_cnt_d;
  logic [3:0]                     clk_cnt_q, clk_cnt_d;
  logic [4:0]                     bit_cnt_q, bit_cnt_d;
  logic [7:0]                     shift_q, shift_d;

`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'(24 * CLK_PER_BIT + 32 - 1);
  logic [9:0] wd_q, wd_d;
  logic       timeout_q, timeout_d;
`endif

  logic in_bits;
  logic slot_first;
  logic slot_end;
  logic last_byte;
  logic final_bit;

  always_comb begin
    in_bits    = (state_q == S_PREAMBLE) || (state_q == S_ACCESS_ADDR) ||
                 (state_q == S_PDU);
    slot_first = (clk_cnt_q == 4'd0);
    slot_end   = (clk_cnt_q == CNT_LAST);
    // Only meaningful in S_PDU, where len_q is at least 1.
    last_byte  = (byte_cnt_q == len_q - LEN_WIDTH'(1));
    // Final bit of the packet: last PDU bit, or AA bit 31 for an empty PDU.
    final_bit  = ((state_q == S_PDU) && (bit_cnt_q == 5'd7) && last_byte) ||
                 ((state_q == S_ACCESS_ADDR) && (bit_cnt_q == 5'd31) &&
                  (len_q == '0));
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    aa_d       = aa_q;
    crc_d      = crc_q;
    len_d      = len_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    clk_cnt_d  = 4'd0;
    if (in_bits) begin
      clk_cnt_d = slot_end ? 4'd0 : clk_cnt_q + 4'd1;
    end
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
    wd_d      = 10'd0;
    timeout_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          aa_d    = access_address;
          crc_d   = crc_init;
          len_d   = pdu_len;
          addr_d  = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        bit_cnt_d = 5'd0;
        state_d   = S_PREAMBLE;
      end

      S_PREAMBLE: begin
        if (slot_end) begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            state_d   = S_ACCESS_ADDR;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      S_ACCESS_ADDR: begin
        if (slot_end) begin
          if (bit_cnt_q == 5'd31) begin
            bit_cnt_d  = 5'd0;
            byte_cnt_d = '0;
            // Byte 0 was addressed at start, so its data is already stable.
            shift_d    = pdu_data;
            state_d    = (len_q == '0) ? S_WAIT_CRC : S_PDU;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      S_PDU: begin
        // Prefetch: address the next byte at the start of this byte so the
        // synchronous buffer read has a full byte time to settle.
        if (slot_first && (bit_cnt_q == 5'd0) && !last_byte) begin
          addr_d = addr_q + LEN_WIDTH'(1);
        end
        if (slot_end) begin
          if (bit_cnt_q == 5'd7) begin
            if (last_byte) begin
              state_d = S_WAIT_CRC;
            end else begin
              byte_cnt_d = byte_cnt_q + LEN_WIDTH'(1);
              bit_cnt_d  = 5'd0;
              shift_d    = pdu_data;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end

      S_WAIT_CRC: begin
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
        wd_d = wd_q + 10'd1;
        if (crc_out_valid_last) begin
          state_d = S_DONE;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
`else
        if (crc_out_valid_last) begin
          state_d = S_DONE;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      aa_q       <= '0;
      crc_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      clk_cnt_q  <= 4'd0;
      bit_cnt_q  <= 5'd0;
      shift_q    <= 8'd0;
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
      wd_q       <= 10'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      aa_q       <= aa_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Outputs decode from registered state, so reset clears them immediately.
  always_comb begin
    info_bit = 1'b0;
    case (state_q)
      S_PREAMBLE:    info_bit = aa_q[0] ^ bit_cnt_q[0];
      S_ACCESS_ADDR: info_bit = aa_q[bit_cnt_q];
      S_PDU:         info_bit = shift_q[0];
      default:       info_bit = 1'b0;
    endcase
  end

  assign info_bit_valid          = in_bits && slot_first;
  assign info_bit_valid_last     = info_bit_valid && final_bit;
  assign crc_state_init_bit_load = (state_q == S_LOAD);
  assign crc_state_init_bit      = (state_q == S_LOAD) ? crc_q : '0;
  assign busy                    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done                    = (state_q == S_DONE);
  assign pdu_addr                = addr_q;
  assign dbg_state               = state_q;
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
  // timeout_q is only ever set on the WAIT_CRC -> DONE edge.
  assign timeout_err             = timeout_q;
`endif

endmodule

// File: tb/tb_btle_crc_tx_seq.sv
// -----------------------------------------------------------------------------
// tb_btle_crc_tx_seq
//
// Bench for btle_crc_tx_seq. The expected on-air bit stream of each packet is
// built from the packet fields and a bench-owned PDU buffer; crc24 is stood in
// for by driving crc_out_valid_last 24 bit slots after the final info bit.
// -----------------------------------------------------------------------------
module tb_btle_crc_tx_seq;

  localparam int CPB = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT wiring
  logic        start;
  logic [31:0] access_address;
  logic [23:0] crc_init;
  logic [7:0]  pdu_len;
  logic [7:0]  pdu_addr;
  logic [7:0]  pdu_data;
  logic        crc_out_valid_last;
  logic [23:0] crc_state_init_bit;
  logic        crc_state_init_bit_load;
  logic        info_bit;
  logic        info_bit_valid;
  logic        info_bit_valid_last;
  logic        busy;
  logic [2:0]  dbg_state;
  logic        done;
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  btle_crc_tx_seq #(
    .CLK_PER_BIT(CPB),
    .CRC_STATE_BIT_WIDTH(24),
    .LEN_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .access_address(access_address),
    .crc_init(crc_init),
    .pdu_len(pdu_len),
    .pdu_addr(pdu_addr),
    .pdu_data(pdu_data),
    .crc_out_valid_last(crc_out_valid_last),
    .crc_state_init_bit(crc_state_init_bit),
    .crc_state_init_bit_load(crc_state_init_bit_load),
    .info_bit(info_bit),
    .info_bit_valid(info_bit_valid),
    .info_bit_valid_last(info_bit_valid_last),
    .busy(busy),
    .dbg_state(dbg_state),
    .done(done)
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  // PDU buffer model with synchronous read
  logic [7:0] mem [0:255];
  always @(posedge clk) pdu_data <= mem[pdu_addr];

  // ---------------------------------------------------------------- scoreboard
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({pdu_addr, info_bit, info_bit_valid, info_bit_valid_last,
                crc_state_init_bit_load, crc_state_init_bit, busy, done});
  endfunction

  // ---------------------------------------------------------------- driver
  // mode 0: normal, 1: start/crc_out_valid_last disturbances,
  // 2: reset during PDU byte 3, 3: crc24 never answers (watchdog).
  task automatic send_packet(input string name, input logic [31:0] aa, input logic [23:0] ci,
                             input logic [7:0] len, input bit zero_mem, input int mode);
    int total, n_valid, bit_err, spacing_err, last_err, load_err, wait_err, busy_err, done_cnt;
    int c_last, c_done, c_mid, c_abort, budget, exp_done;
    logic [7:0] pre_bits;
    logic [0:0] exp_bit;
    logic load_ok, busy_at_done, end_idle, aborted, to_seen;

    total = 40 + 8 * int'(len);
    n_valid = 0; bit_err = 0; spacing_err = 0; last_err = 0; load_err = 0;
    wait_err = 0; busy_err = 0; done_cnt = 0;
    c_last = -1; c_done = -1;
    c_mid   = 2 + CPB * 41 + 3;            // PDU byte 0, bit 1
    c_abort = 2 + CPB * (40 + 24) + 5;     // PDU byte 3, bit 0
    budget  = 2 + CPB * total + CPB + 24 * CPB + 64;
    pre_bits = 8'h00; load_ok = 1'b0; busy_at_done = 1'b1; end_idle = 1'b0;
    aborted = 1'b0; to_seen = 1'b0;

    for (int b = 0; b < 256; b++) mem[8'(b)] = zero_mem ? 8'h00 : 8'($urandom);

    // Expected on-air sequence: alternating preamble, AA LSB first, PDU bytes LSB first.
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(1'((k % 2) ^ int'(aa[0])));
    for (int i = 0; i < 32; i++) exp_q.push_back(aa[5'(i)]);
    for (int b = 0; b < int'(len); b++)
      for (int i = 0; i < 8; i++) exp_q.push_back(mem[8'(b)][3'(i)]);

    @(negedge clk);
    start = 1'b1; access_address = aa; crc_init = ci; pdu_len = len;

    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (mode == 2 && c == c_abort) begin
        #2 rst = 1'b1;
        #1 check({name, ".async_reset_outputs"}, outs_vec(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end

      // ---- sample
      if (c == 1)
        load_ok = (crc_state_init_bit_load === 1'b1) && (crc_state_init_bit === ci) && (busy === 1'b1);
      else if (crc_state_init_bit_load !== 1'b0) load_err++;

      if (info_bit_valid === 1'b1) begin
        if (n_valid < total) begin
          exp_bit = exp_q.pop_front();
          if (info_bit !== exp_bit[0]) bit_err++;
          if (n_valid < 8) pre_bits[3'(n_valid)] = info_bit;
          if (c != 2 + CPB * n_valid) spacing_err++;
          if (info_bit_valid_last !== 1'(n_valid == total - 1)) last_err++;
          if (n_valid == total - 1) c_last = c;
        end
        n_valid++;
      end else if (info_bit_valid_last !== 1'b0) last_err++;

      if (c_last >= 0 && c >= c_last + CPB && (info_bit_valid || info_bit || info_bit_valid_last))
        wait_err++;

      if (done === 1'b1) begin
        done_cnt++;
        if (c_done < 0) begin
          c_done = c;
          busy_at_done = busy;
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
          to_seen = timeout_err;
`endif
        end
      end else if (c_done < 0 && busy !== 1'b1) busy_err++;

      if (c_done >= 0 && c == c_done + 2) end_idle = (busy === 1'b0) && (done === 1'b0);

      // ---- drive
      if (c == 1) begin
        start = 1'b0;
        access_address = $urandom;
        crc_init = 24'($urandom);
        pdu_len = 8'($urandom);
      end
      if (mode == 1 && (c == c_mid || (c_last >= 0 && c == c_last + 100))) begin
        start = 1'b1;
        access_address = $urandom;
        crc_init = 24'($urandom);
        pdu_len = 8'($urandom);
        crc_out_valid_last = (c == c_mid);
      end else if (mode == 1 && (c == c_mid + 1 || (c_last >= 0 && c == c_last + 101))) begin
        start = 1'b0;
        crc_out_valid_last = 1'b0;
      end
      if (mode != 3 && c_last >= 0 && c == c_last + 24 * CPB) crc_out_valid_last = 1'b1;
      if (c_last >= 0 && c == c_last + 24 * CPB + 1) crc_out_valid_last = 1'b0;
      if (c_done >= 0 && c == c_done + 2) break;
    end

    if (!aborted) begin
      exp_done = (mode == 3) ? c_last + CPB + 24 * CPB + 32 : c_last + 24 * CPB + 1;
      check({name, ".load"}, 64'(load_ok), 64'd1);
      check({name, ".load_extra"}, 64'(load_err), 64'd0);
      check({name, ".valid_count"}, 64'(n_valid), 64'(total));
      check({name, ".bits"}, 64'(bit_err), 64'd0);
      check({name, ".preamble"}, 64'(pre_bits), aa[0] ? 64'h55 : 64'hAA);
      check({name, ".spacing"}, 64'(spacing_err), 64'd0);
      check({name, ".valid_last"}, 64'(last_err), 64'd0);
      check({name, ".last_slot"}, 64'(c_last), 64'(2 + CPB * (total - 1)));
      check({name, ".wait_quiet"}, 64'(wait_err), 64'd0);
      check({name, ".busy"}, 64'(busy_err), 64'd0);
      check({name, ".done_count"}, 64'(done_cnt), 64'd1);
      check({name, ".done_time"}, 64'(c_done), 64'(exp_done));
      check({name, ".busy_at_done"}, 64'(busy_at_done), 64'd0);
      check({name, ".idle_after"}, 64'(end_idle), 64'd1);
      check({name, ".pdu_addr_end"}, 64'(pdu_addr), (len == 8'd0) ? 64'd0 : 64'(len - 8'd1));
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
      check({name, ".timeout_err"}, 64'(to_seen), 64'(mode == 3));
`endif
    end
  endtask

  // ---------------------------------------------------------------- directed sequence
  initial begin
    rst = 1'b1;
    start = 1'b0;
    access_address = 32'h0;
    crc_init = 24'h0;
    pdu_len = 8'h0;
    crc_out_valid_last = 1'b0;
    for (int b = 0; b < 256; b++) mem[8'(b)] = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs_vec(), 64'd0);

    send_packet("adv_len2", 32'h8E89BED6, 24'h555555, 8'd2, 1'b1, 0);
    send_packet("aa_lsb1", 32'h8E89BED7, 24'h555555, 8'($urandom_range(1, 4)), 1'b0, 0);
    send_packet("len0", $urandom, 24'($urandom), 8'd0, 1'b0, 0);
    send_packet("disturb", $urandom, 24'($urandom), 8'd5, 1'b0, 1);
    send_packet("abort", $urandom, 24'($urandom), 8'd6, 1'b0, 2);
    send_packet("after_abort", $urandom, 24'($urandom), 8'd6, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      send_packet($sformatf("rand%0d", i), $urandom, 24'($urandom),
                  8'($urandom_range(0, 12)), 1'b0, 0);
    send_packet("len255", $urandom, 24'($urandom), 8'd255, 1'b0, 0);
`ifdef BTLE_CRC_SEQ_TIMEOUT_EN
    send_packet("timeout", $urandom, 24'($urandom), 8'd3, 1'b0, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
